// File: rtl/sect239k1_pkg.sv
// Shared constants and FSM state type for the sect239k1 point-multiplier bus interface.
package sect239k1_pkg;

  localparam int unsigned M           = 239;  // field degree, bits per coordinate
  localparam int unsigned WORD_W      = 32;   // bus word width
  localparam int unsigned N_D_WORDS   = 8;    // scalar words on the load stream
  localparam int unsigned N_RES_WORDS = 16;   // result words on the read stream (x then y)
  localparam int unsigned TOP_BITS    = 15;   // valid bits in the top word of a 239-bit value

  typedef enum logic [1:0] {
    StLoad,
    StStart,
    StWait,
    StUnload
  } state_e;

endpackage

// File: rtl/sect239k1_res_shreg.sv
// Result serializer: captures {y, x} (478 bits) and shifts it out as 16 words,
// x LSW first, then y LSW first. The top word of each coordinate carries 15 bits,
// zero-extended.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clr_i          discard the held result, word counter to 0
//   load_i         capture x_i/y_i, word counter to 0
//   shift_i        advance to the next word
//   data_o         current word
//   last_o         current word is the final (16th) word
module sect239k1_res_shreg
  import sect239k1_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [M-1:0]      x_i,
  input  logic [M-1:0]      y_i,
  output logic [WORD_W-1:0] data_o,
  output logic              last_o
);

  logic [2*M-1:0] res_q, res_d;
  logic [3:0]     idx_q, idx_d;
  logic           top_word;

  // Words 7 and 15 are the 15-bit tops of x and y.
  assign top_word = (idx_q[2:0] == 3'd7);

  always_comb begin
    res_d = res_q;
    idx_d = idx_q;
    if (clr_i) begin
      res_d = '0;
      idx_d = '0;
    end else if (load_i) begin
      res_d = {y_i, x_i};
      idx_d = '0;
    end else if (shift_i) begin
      // After x's 15-bit top word only 15 bits are consumed, leaving y aligned at bit 0.
      res_d = top_word ? (res_q >> TOP_BITS) : (res_q >> WORD_W);
      idx_d = idx_q + 4'd1;
    end
  end

  always_comb begin
    data_o = res_q[WORD_W-1:0];
    // At x's top word the low bits of y sit above bit 14; mask them off.
    if (top_word) data_o[WORD_W-1:TOP_BITS] = '0;
    last_o = (idx_q == 4'(N_RES_WORDS - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q <= '0;
      idx_q <= '0;
    end else begin
      res_q <= res_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sect239k1_pt_mul_bus_if.sv
// Bus front-end for the sect239k1 point multiplier core.
// Loads a 239-bit scalar as 8 words, starts the core, waits for completion
// (optional timeout), then streams x and y out as 16 words.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   abort                       drop the current operation, return to load
//   wr_valid/wr_ready/wr_data   scalar load stream
//   rd_valid/rd_ready/rd_data/rd_last   result stream
//   busy                        operation in progress (not loading)
//   err                         sticky timeout flag
//   core_clr/core_start/core_d/core_done/core_x/core_y   core handshake
module sect239k1_pt_mul_bus_if
  import sect239k1_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              err,
  output logic              core_clr,
  output logic              core_start,
  output logic [M-1:0]      core_d,
  input  logic              core_done,
  input  logic [M-1:0]      core_x,
  input  logic [M-1:0]      core_y
);

  localparam int unsigned LdW = (N_D_WORDS - 1) * WORD_W;

  state_e          state_q, state_d;
  logic [2:0]      widx_q, widx_d;
  logic [LdW-1:0]  ld_q, ld_d;      // words 0..6 of the scalar being loaded
  logic [M-1:0]    core_d_q, core_d_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            clr_q, clr_d;    // core_clr pulse following an abort
  logic            timeout;
  logic            res_load, res_shift, res_clr;
  logic [WORD_W-1:0] res_data;
  logic            res_last;

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    ld_d      = ld_q;
    core_d_d  = core_d_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    clr_d     = abort;
    timeout   = 1'b0;
    res_load  = 1'b0;
    res_shift = 1'b0;
    res_clr   = 1'b0;
    if (abort) begin
      state_d = StLoad;
      widx_d  = '0;
      cnt_d   = '0;
      res_clr = 1'b1;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (wr_valid) begin
            for (int n = 0; n < int'(N_D_WORDS) - 1; n++) begin
              if (widx_q == 3'(n)) ld_d[n*WORD_W +: WORD_W] = wr_data;
            end
            if (widx_q == 3'(N_D_WORDS - 1)) begin
              // core_d only changes when a full scalar has arrived.
              core_d_d = {wr_data[TOP_BITS-1:0], ld_q};
              widx_d   = '0;
              state_d  = StStart;
            end else begin
              widx_d = widx_q + 3'd1;
            end
          end
        end
        StStart: begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StWait;
        end
        StWait: begin
          if (core_done) begin
            res_load = 1'b1;
            state_d  = StUnload;
          end else if (WAIT_MAX != 0 && cnt_q == WAIT_MAX) begin
            timeout = 1'b1;
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = StLoad;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StUnload: begin
          if (rd_ready) begin
            res_shift = 1'b1;
            if (res_last) state_d = StLoad;
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLoad;
      widx_q   <= '0;
      ld_q     <= '0;
      core_d_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      ld_q     <= ld_d;
      core_d_q <= core_d_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      clr_q    <= clr_d;
    end
  end

  sect239k1_res_shreg u_res_shreg (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (res_clr),
    .load_i  (res_load),
    .shift_i (res_shift),
    .x_i     (core_x),
    .y_i     (core_y),
    .data_o  (res_data),
    .last_o  (res_last)
  );

  // Handshake outputs depend on state only (plus rst), never on wr_valid/rd_ready.
  always_comb begin
    wr_ready   = !rst && (state_q == StLoad);
    rd_valid   = !rst && (state_q == StUnload);
    core_start = !rst && (state_q == StStart);
    busy       = !rst && (state_q != StLoad);
    core_clr   = rst || clr_q || timeout;
    rd_data    = rd_valid ? res_data : '0;
    rd_last    = rd_valid && res_last;
    err        = err_q;
    core_d     = core_d_q;
  end

endmodule

// File: tb/tb_sect239k1_pt_mul_bus_if.sv
module tb_sect239k1_pt_mul_bus_if;
  import sect239k1_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              abort = 1'b0;
  logic              wr_valid = 1'b0;
  logic [31:0]       wr_data = '0;
  logic              rd_ready = 1'b0;
  logic              wr_ready, rd_valid, rd_last, busy, err, core_clr, core_start;
  logic [31:0]       rd_data;
  logic [M-1:0]      core_d;
  logic              core_done;
  logic [M-1:0]      core_x, core_y;

  // Second instance with a timeout, fed by a core that never finishes.
  logic              wr_valid_t = 1'b0;
  logic              wr_ready_t, rd_valid_t, rd_last_t, busy_t, err_t, core_clr_t, core_start_t;
  logic [31:0]       rd_data_t;
  logic [M-1:0]      core_d_t;

  int n_vec = 0;
  int n_err = 0;

  sect239k1_pt_mul_bus_if #(.WAIT_MAX(0)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .err(err),
    .core_clr(core_clr), .core_start(core_start), .core_d(core_d),
    .core_done(core_done), .core_x(core_x), .core_y(core_y)
  );

  sect239k1_pt_mul_bus_if #(.WAIT_MAX(10)) dut_to (
    .clk(clk), .rst(rst), .abort(1'b0),
    .wr_valid(wr_valid_t), .wr_ready(wr_ready_t), .wr_data(wr_data),
    .rd_valid(rd_valid_t), .rd_ready(1'b1), .rd_data(rd_data_t), .rd_last(rd_last_t),
    .busy(busy_t), .err(err_t),
    .core_clr(core_clr_t), .core_start(core_start_t), .core_d(core_d_t),
    .core_done(1'b0), .core_x({M{1'b0}}), .core_y({M{1'b0}})
  );

  // Core model: done pulses about 20 cycles after core_start with fixed x, y.
  assign core_x = 239'h1234;
  assign core_y = {M{1'b1}};
  int core_cnt;
  always @(posedge clk) begin
    if (rst) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (core_start) core_cnt <= 20;
      else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) core_done <= 1'b1;
      end
    end
  end

  logic [31:0] exp_w [16];
  initial begin
    exp_w[0] = 32'h0000_1234;
    for (int i = 1; i < 8; i++) exp_w[i] = 32'h0;
    for (int i = 8; i < 15; i++) exp_w[i] = 32'hFFFF_FFFF;
    exp_w[15] = 32'h0000_7FFF;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Eight beats; returns sampled just after the 8th accepted edge.
  task automatic load8(input bit tgt, input logic [31:0] w0, input logic [31:0] w7);
    for (int i = 0; i < 8; i++) begin
      wr_data = (i == 0) ? w0 : ((i == 7) ? w7 : 32'h0);
      if (tgt) wr_valid_t = 1'b1;
      else     wr_valid   = 1'b1;
      cycle();
    end
    wr_valid   = 1'b0;
    wr_valid_t = 1'b0;
  endtask

  task automatic unload(input bit stall);
    int i = 0;
    int k = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int b = 0; b < 100 && !rd_valid; b++) cycle();
    check("rd_valid_seen", rd_valid, 1);
    while (i < 16 && k < 200) begin
      rd_ready = stall ? pat[k % 4] : 1'b1;
      check($sformatf("rd_data[%0d]", i), rd_data, exp_w[i]);
      check($sformatf("rd_last[%0d]", i), rd_last, (i == 15));
      cycle();
      if (rd_ready) i++;
      k++;
    end
    rd_ready = 1'b0;
    check("words_done", i, 16);
    check("wr_ready_after_last", wr_ready, 1);
    check("rd_valid_after_last", rd_valid, 0);
  endtask

  initial begin
    // Reset state
    cycle();
    cycle();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_core_clr", core_clr, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_d", core_d, 0);
    rst = 1'b0;
    #1;
    check("post_rst_wr_ready", wr_ready, 1);
    check("post_rst_core_clr", core_clr, 0);
    cycle();

    // Scalar = 1, full unload without stalls
    load8(1'b0, 32'h1, 32'h0);
    check("t1_core_start", core_start, 1);
    check("t1_busy", busy, 1);
    check("t1_wr_ready", wr_ready, 0);
    check("t1_core_d", core_d, 239'h1);
    cycle();
    check("t1_start_once", core_start, 0);
    unload(1'b0);

    // Top word truncated to 15 bits; unload with 1,0,0,1 rd_ready pattern
    load8(1'b0, 32'h0, 32'hFFFF_FFFF);
    check("t2_core_d", core_d, {15'h7FFF, 224'h0});
    check("t2_err", err, 0);
    unload(1'b1);

    // Abort mid-load, coinciding with a beat: partial scalar dropped
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hAAAA_AAAA;
      cycle();
    end
    abort = 1'b1;
    cycle();
    abort    = 1'b0;
    wr_valid = 1'b0;
    check("ab_load_core_clr", core_clr, 1);
    check("ab_load_wr_ready", wr_ready, 1);
    cycle();
    check("ab_load_clr_pulse", core_clr, 0);
    load8(1'b0, 32'h5, 32'h0);
    check("ab_load_core_start", core_start, 1);
    check("ab_load_core_d", core_d, 239'h5);

    // Abort on the same cycle as core_done
    begin
      int b = 0;
      while (!core_done && b < 100) begin
        cycle();
        b++;
      end
    end
    check("ab_done_seen", core_done, 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("ab_done_core_clr", core_clr, 1);
    check("ab_done_rd_valid", rd_valid, 0);
    check("ab_done_wr_ready", wr_ready, 1);
    check("ab_done_busy", busy, 0);
    check("ab_done_err", err, 0);
    cycle();
    check("ab_done_clr_once", core_clr, 0);
    check("ab_done_rd_valid2", rd_valid, 0);

    // Timeout instance: WAIT_MAX = 10, core never done
    load8(1'b1, 32'h7, 32'h0);
    check("to_core_start", core_start_t, 1);
    cycle();                            // WAIT cycle 0
    for (int i = 0; i < 9; i++) cycle(); // WAIT cycle 9
    check("to_no_early_clr", core_clr_t, 0);
    cycle();                            // WAIT cycle 10
    check("to_core_clr", core_clr_t, 1);
    check("to_busy", busy_t, 1);
    cycle();
    check("to_err", err_t, 1);
    check("to_wr_ready", wr_ready_t, 1);
    check("to_clr_once", core_clr_t, 0);
    load8(1'b1, 32'h9, 32'h0);
    check("to_err_held_in_start", err_t, 1);
    cycle();
    check("to_err_cleared", err_t, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
